// File: rtl/mux_sel_pkg.sv
// Shared types, constants and the select-code map for the mux select arbiter.
package mux_sel_pkg;

   localparam int NUM_REQ = 10;
   localparam logic [3:0] SEL_IDLE = 4'b1111;
   localparam logic [3:0] OWNER_NONE = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Requesters 0..7 map straight onto the low codes. Requesters 8 and 9
   // skip over 1000..1100, which the mux does not use.
   function automatic logic [3:0] idx2sel(input logic [3:0] idx);
      logic [3:0] code;
      code = SEL_IDLE;
      if (idx < 4'd8) begin
         code = idx;
      end else if (idx == 4'd8) begin
         code = 4'b1101;
      end else if (idx == 4'd9) begin
         code = 4'b1110;
      end
      return code;
   endfunction

endpackage

// File: rtl/rr_pick10.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping modulo 10) that is requesting wins.
module rr_pick10
   import mux_sel_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [3:0]         last,
   output logic [3:0]         win,
   output logic               any
);

   logic [4:0] cand;

   // Walk the ten positions starting just after the previous winner.
   always_comb begin
      win  = 4'd0;
      any  = 1'b0;
      cand = 5'd0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, last} + 5'(i);
         if (cand >= 5'(NUM_REQ)) begin
            cand = cand - 5'(NUM_REQ);
         end
         if (!any && req[cand]) begin
            any = 1'b1;
            win = cand[3:0];
         end
      end
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that hands the shared mux output line to one of ten
// requesters at a time and drives the mux select pins with the owner's code.
// A one-cycle GAP separates consecutive grants so ownership never changes
// hands between two back-to-back cycles.
module mux_sel_arbiter
   import mux_sel_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               c1,
   output logic               c2,
   output logic               c3,
   output logic               c4,
   output logic [3:0]         owner,
   output logic               busy
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [3:0]         last, last_nxt;
   logic [3:0]         sel, sel_nxt;
   logic [3:0]         owner_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic               busy_nxt;
   logic [3:0]         win;
   logic               any;
   logic               owner_req;
   logic               hold_done;

   rr_pick10 u_pick (
      .req  (req),
      .last (last),
      .win  (win),
      .any  (any)
   );

   // gnt is one-hot on the owner, so masking req with it isolates the
   // owner's request bit without indexing by the idle owner value.
   assign owner_req = |(req & gnt);
   assign hold_done = (cnt == CNT_W'(MAX_HOLD - 1));

   assign {c1, c2, c3, c4} = sel;

   // Next-state and next-output logic; outputs are registered from here.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      owner_nxt = owner;
      busy_nxt  = busy;
      case (state)
         ST_IDLE, ST_GAP: begin
            if (any) begin
               state_nxt = ST_GRANT;
               cnt_nxt   = '0;
               last_nxt  = win;
               gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
               sel_nxt   = idx2sel(win);
               owner_nxt = win;
               busy_nxt  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               gnt_nxt   = '0;
               sel_nxt   = SEL_IDLE;
               owner_nxt = OWNER_NONE;
               busy_nxt  = 1'b0;
            end
         end
         ST_GRANT: begin
            if (!owner_req || hold_done) begin
               state_nxt = ST_GAP;
               gnt_nxt   = '0;
               sel_nxt   = SEL_IDLE;
               owner_nxt = OWNER_NONE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            sel_nxt   = SEL_IDLE;
            owner_nxt = OWNER_NONE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State, hold counter, RR pointer and output registers. The pointer
   // resets to 9 so requester 0 has first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         last  <= 4'(NUM_REQ - 1);
         gnt   <= '0;
         sel   <= SEL_IDLE;
         owner <= OWNER_NONE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         owner <= owner_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with hand-computed expected values.
module tb_mux_sel_arbiter;

   logic       clk;
   logic       rst_n;
   logic [9:0] req;
   logic [9:0] gnt;
   logic       c1, c2, c3, c4;
   logic [3:0] owner;
   logic       busy;
   logic [3:0] sel;

   int checks = 0;
   int fails  = 0;
   logic mon_ok;

   assign sel = {c1, c2, c3, c4};

   mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt),
      .c1    (c1),
      .c2    (c2),
      .c3    (c3),
      .c4    (c4),
      .owner (owner),
      .busy  (busy)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected select code for a requester index
   function automatic logic [3:0] expSel(input int idx);
      case (idx)
         0: return 4'b0000;
         1: return 4'b0001;
         2: return 4'b0010;
         3: return 4'b0011;
         4: return 4'b0100;
         5: return 4'b0101;
         6: return 4'b0110;
         7: return 4'b0111;
         8: return 4'b1101;
         9: return 4'b1110;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] r);
      req = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
      checkOutput({tag, "_sel"}, 32'(sel), 32'hF);
      checkOutput({tag, "_owner"}, 32'(owner), 32'd15);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic checkGrant(input string tag, input int idx);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'(10'b1 << idx));
      checkOutput({tag, "_sel"}, 32'(sel), 32'(expSel(idx)));
      checkOutput({tag, "_owner"}, 32'(owner), 32'(idx));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   // Every cycle out of reset: legal select code, one-hot-or-zero grant,
   // and grant/select/owner/busy consistent with each other.
   always @(negedge clk) begin
      if (rst_n) begin
         mon_ok = 1'b1;
         if (sel >= 4'd8 && sel <= 4'd12) mon_ok = 1'b0;
         if ((gnt & (gnt - 10'd1)) != 10'd0) mon_ok = 1'b0;
         if (gnt != 10'd0) begin
            if (owner > 4'd9) mon_ok = 1'b0;
            else if (gnt != (10'b1 << owner) || sel != expSel(int'(owner)) || !busy) mon_ok = 1'b0;
         end else begin
            if (sel != 4'hF || owner != 4'd15 || busy) mon_ok = 1'b0;
         end
         checkOutput("invariant", 32'(mon_ok), 32'd1);
      end
   end

   // Directed scenario sequence
   initial begin
      rst_n = 1'b0;
      applyStimulus(10'h000);
      #12;
      checkIdle("reset");
      tick();
      rst_n = 1'b1;
      tick();
      checkIdle("idle_after_reset");

      // Single request on index 8, kept for 3 cycles after the grant cycle
      applyStimulus(10'h100);
      tick();
      checkGrant("single", 8);
      for (int h = 0; h < 3; h++) begin
         tick();
         checkOutput("single_hold", 32'(gnt), 32'h100);
      end
      applyStimulus(10'h000);
      tick();
      checkIdle("single_gap");
      tick();
      checkIdle("single_idle");

      // Hold expiry on index 9: 8 grant cycles, one gap, then regrant
      applyStimulus(10'h200);
      tick();
      checkGrant("expiry", 9);
      for (int h = 1; h < 8; h++) begin
         tick();
         checkOutput("expiry_hold", 32'(sel), 32'hE);
      end
      tick();
      checkIdle("expiry_gap");
      tick();
      checkGrant("expiry_regrant", 9);
      applyStimulus(10'h000);
      tick();
      checkIdle("expiry_gap2");
      tick();
      checkIdle("expiry_idle");

      // Full round robin with all requesters active: 0..9 then 0 again
      applyStimulus(10'h3FF);
      for (int k = 0; k <= 10; k++) begin
         tick();
         checkGrant("rr_grant", k % 10);
         for (int h = 1; h < 8; h++) begin
            tick();
            checkOutput("rr_hold", 32'(gnt), 32'(10'b1 << (k % 10)));
         end
         tick();
         checkIdle("rr_gap");
      end
      applyStimulus(10'h000);
      tick();
      checkIdle("rr_idle");

      // Move the pointer to 9, then 0 and 9 compete: 0 wins, then 9
      applyStimulus(10'h200);
      tick();
      checkGrant("wrap_pre", 9);
      applyStimulus(10'h000);
      tick();
      tick();
      applyStimulus(10'h201);
      tick();
      checkGrant("wrap_first", 0);
      applyStimulus(10'h200);
      tick();
      checkIdle("wrap_gap");
      tick();
      checkGrant("wrap_second", 9);
      applyStimulus(10'h000);
      tick();
      tick();
      checkIdle("wrap_idle");

      // Owner drops request in its expiry cycle; new request during the gap
      applyStimulus(10'h010);
      tick();
      checkGrant("simul", 4);
      for (int h = 1; h < 8; h++) begin
         tick();
         checkOutput("simul_hold", 32'(gnt), 32'h010);
      end
      applyStimulus(10'h000);
      tick();
      checkIdle("simul_gap");
      applyStimulus(10'h004);
      tick();
      checkGrant("simul_regrant", 2);
      applyStimulus(10'h000);
      tick();
      tick();
      checkIdle("simul_idle");

      // Asynchronous reset in the middle of a grant
      applyStimulus(10'h008);
      tick();
      checkGrant("midrst_grant", 3);
      #2;
      rst_n = 1'b0;
      #1;
      checkIdle("midrst_async");
      applyStimulus(10'h000);
      tick();
      rst_n = 1'b1;
      tick();
      checkIdle("midrst_after");

      // Pointer is back at 9 after reset, so 0 beats 9
      applyStimulus(10'h201);
      tick();
      checkGrant("post_reset_prio", 0);
      applyStimulus(10'h000);
      tick();
      tick();
      checkIdle("final_idle");

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
